// File: rtl/bloom_pkg.sv
// Shared types, hash constants and sizing helper for the Bloom-filter unit.
package bloom_pkg;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_INSERT = 2'b01,
    OP_CHECK  = 2'b10,
    OP_CLEAR  = 2'b11
  } bloom_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HASH,
    ST_ACCESS,
    ST_CLEAR
  } bloom_state_e;

  localparam logic [31:0] HASH_C [4] = '{
    32'h9E3779B1, 32'h85EBCA77, 32'hC2B2AE3D, 32'h27D4EB2F
  };

  // Index width for an n-entry space; never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bloom_hash.sv
// Combinational multiplicative hashing: one 32-bit key in, K_HASH filter indices out.
module bloom_hash
  import bloom_pkg::*;
#(
  parameter int unsigned M_BITS = 256,
  parameter int unsigned K_HASH = 3,
  parameter int unsigned IDX_W  = idx_width(M_BITS)
) (
  input  logic [31:0]                  key_i,
  output logic [K_HASH-1:0][IDX_W-1:0] idx_o
);

  // Index is the top IDX_W bits of the low 32-bit product word.
  always_comb begin
    idx_o = '0;
    for (int unsigned k = 0; k < K_HASH; k++) begin
      idx_o[k] = IDX_W'((key_i * HASH_C[k]) >> (32 - IDX_W));
    end
  end

endmodule

// File: rtl/bloom_filter_unit.sv
// Bloom-filter storage/lookup engine: insert, check and word-sweep clear over a
// valid/ready request port with a registered one-cycle response pulse.
module bloom_filter_unit
  import bloom_pkg::*;
#(
  parameter int unsigned M_BITS = 256,
  parameter int unsigned K_HASH = 3,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_op_i,
  input  logic [31:0]      req_data_i,
  output logic             resp_valid_o,
  output logic             resp_match_o,
  output logic             resp_err_o,
  output logic [CNT_W-1:0] elem_count_o
);

  localparam int unsigned IDX_W   = idx_width(M_BITS);
  localparam int unsigned N_WORDS = M_BITS / WORD_W;
  localparam int unsigned PTR_W   = idx_width(N_WORDS);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N_WORDS - 1);

  bloom_state_e                  state_q, state_d;
  bloom_op_e                     op_q;
  bloom_op_e                     req_op;
  logic [31:0]                   key_q;
  logic [K_HASH-1:0][IDX_W-1:0]  hash_idx;
  logic [K_HASH-1:0][IDX_W-1:0]  idx_q;
  logic [PTR_W-1:0]              ptr_q;
  logic [M_BITS-1:0]             filter_q;
  logic [CNT_W-1:0]              count_q;
  logic                          resp_valid_q, resp_match_q, resp_err_q;
  logic                          accept;
  logic                          hit;

  assign req_op = bloom_op_e'(req_op_i);

  bloom_hash #(
    .M_BITS (M_BITS),
    .K_HASH (K_HASH),
    .IDX_W  (IDX_W)
  ) u_hash (
    .key_i (key_q),
    .idx_o (hash_idx)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          accept = 1'b1;
          unique case (req_op)
            OP_INSERT, OP_CHECK: state_d = ST_HASH;
            OP_CLEAR:            state_d = ST_CLEAR;
            default:             state_d = ST_IDLE;
          endcase
        end
      end
      ST_HASH:   state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_IDLE;
      ST_CLEAR:  if (ptr_q == LAST_PTR) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Match is taken from the array contents before this cycle's insert write.
  always_comb begin
    hit = 1'b1;
    for (int unsigned k = 0; k < K_HASH; k++) begin
      hit = hit & filter_q[idx_q[k]];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q         <= OP_NOP;
      key_q        <= '0;
      idx_q        <= '0;
      ptr_q        <= '0;
      filter_q     <= '0;
      count_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_match_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_match_q <= 1'b0;
      resp_err_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            ptr_q <= '0;
            if (req_op == OP_NOP) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              key_q <= req_data_i;
              op_q  <= req_op;
            end
          end
        end
        ST_HASH: idx_q <= hash_idx;
        ST_ACCESS: begin
          resp_valid_q <= 1'b1;
          resp_match_q <= hit;
          if (op_q == OP_INSERT) begin
            for (int unsigned k = 0; k < K_HASH; k++) begin
              filter_q[idx_q[k]] <= 1'b1;
            end
            if (!hit && (count_q != '1)) count_q <= count_q + CNT_W'(1);
          end
        end
        ST_CLEAR: begin
          filter_q[ptr_q*WORD_W +: WORD_W] <= '0;
          ptr_q <= ptr_q + PTR_W'(1);
          if (ptr_q == LAST_PTR) begin
            count_q      <= '0;
            resp_valid_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready_o  = (state_q == ST_IDLE);
  assign resp_valid_o = resp_valid_q;
  assign resp_match_o = resp_match_q;
  assign resp_err_o   = resp_err_q;
  assign elem_count_o = count_q;

endmodule

// File: tb/tb_bloom_filter_unit.sv
// Scoreboard bench for bloom_filter_unit: directed requests push expected
// responses; a negedge monitor pops and compares whenever a response appears.
module tb_bloom_filter_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_data;
  logic        resp_valid;
  logic        resp_match;
  logic        resp_err;
  logic [15:0] elem_count;

  bloom_filter_unit #(
    .M_BITS (256),
    .K_HASH (3),
    .WORD_W (32),
    .CNT_W  (16)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_op_i     (req_op),
    .req_data_i   (req_data),
    .resp_valid_o (resp_valid),
    .resp_match_o (resp_match),
    .resp_err_o   (resp_err),
    .elem_count_o (elem_count)
  );

  localparam logic [1:0] NOP = 2'b00, INS = 2'b01, CHK = 2'b10, CLR = 2'b11;

  typedef struct {
    logic        m;
    logic        e;
    logic [15:0] c;
    int unsigned due;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk($sformatf("%s_match", mon_e.name), {31'd0, resp_match}, {31'd0, mon_e.m});
        chk($sformatf("%s_err", mon_e.name), {31'd0, resp_err}, {31'd0, mon_e.e});
        chk($sformatf("%s_count", mon_e.name), {16'd0, elem_count}, {16'd0, mon_e.c});
        chk($sformatf("%s_cycle", mon_e.name), cyc, mon_e.due);
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [31:0] d, input logic em,
                      input logic ee, input logic [15:0] ec, input int unsigned lat,
                      input string name, input bit hold, output int unsigned acc);
    exp_t x;
    int unsigned t = 0;
    @(negedge clk);
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    acc = cyc;
    if (!req_ready) begin
      chk($sformatf("%s_ready_timeout", name), 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    req_valid = 1'b1;
    req_op    = op;
    req_data  = d;
    @(posedge clk);
    #1;
    acc    = cyc;
    x.m    = em;
    x.e    = ee;
    x.c    = ec;
    x.due  = cyc + lat;
    x.name = name;
    exp_q.push_back(x);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    chk("drain_pending", exp_q.size(), 32'd0);
  endtask

  task automatic check_idle_after_reset(input string name);
    chk($sformatf("%s_ready", name), {31'd0, req_ready}, 32'd1);
    chk($sformatf("%s_count", name), {16'd0, elem_count}, 32'd0);
    chk($sformatf("%s_resp_valid", name), {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    int unsigned a0, a1, a2, a3;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = NOP;
    req_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_idle_after_reset("reset");

    // Key 1 -> indices 158,133,194; key 0 -> 0,0,0; key 2 -> 60,11,133.
    send(CHK, 32'h1, 1'b0, 1'b0, 16'd0, 2, "chk1_empty", 1'b0, a0);
    send(INS, 32'h1, 1'b0, 1'b0, 16'd1, 2, "ins1", 1'b0, a0);
    send(CHK, 32'h1, 1'b1, 1'b0, 16'd1, 2, "chk1_hit", 1'b0, a0);
    send(INS, 32'h1, 1'b1, 1'b0, 16'd1, 2, "ins1_dup", 1'b0, a0);
    send(INS, 32'h0, 1'b0, 1'b0, 16'd2, 2, "ins0", 1'b0, a0);
    send(CHK, 32'h0, 1'b1, 1'b0, 16'd2, 2, "chk0_hit", 1'b0, a0);
    send(CHK, 32'h2, 1'b0, 1'b0, 16'd2, 2, "chk2_miss", 1'b0, a0);
    drain();

    send(CLR, 32'h0, 1'b0, 1'b0, 16'd0, 8, "clear", 1'b0, a0);
    send(CHK, 32'h1, 1'b0, 1'b0, 16'd0, 2, "chk1_cleared", 1'b0, a0);
    send(CHK, 32'h0, 1'b0, 1'b0, 16'd0, 2, "chk0_cleared", 1'b0, a0);

    send(NOP, 32'hDEAD, 1'b0, 1'b1, 16'd0, 0, "nop", 1'b0, a0);
    send(INS, 32'h2, 1'b0, 1'b0, 16'd1, 2, "ins2", 1'b0, a0);
    drain();

    send(CHK, 32'h2, 1'b1, 1'b0, 16'd1, 2, "b2b_1", 1'b1, a1);
    send(CHK, 32'h2, 1'b1, 1'b0, 16'd1, 2, "b2b_2", 1'b1, a2);
    send(CHK, 32'h2, 1'b1, 1'b0, 16'd1, 2, "b2b_3", 1'b0, a3);
    chk("b2b_spacing_12", a2 - a1, 32'd3);
    chk("b2b_spacing_23", a3 - a2, 32'd3);
    drain();

    // Reset while a clear sweep sits at word pointer 3.
    send(INS, 32'h1, 1'b0, 1'b0, 16'd2, 2, "ins1_pre_rst", 1'b0, a0);
    drain();
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = CLR;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_idle_after_reset("rst_clear");
    repeat (12) @(negedge clk);
    send(CHK, 32'h1, 1'b0, 1'b0, 16'd0, 2, "chk1_after_rst", 1'b0, a0);
    send(CHK, 32'h2, 1'b0, 1'b0, 16'd0, 2, "chk2_after_rst", 1'b0, a0);

    // Reset while an insert is in HASH.
    send(INS, 32'h0, 1'b0, 1'b0, 16'd1, 2, "ins0_pre_rst", 1'b0, a0);
    drain();
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = INS;
    req_data  = 32'h1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_idle_after_reset("rst_hash");
    repeat (6) @(negedge clk);
    send(CHK, 32'h0, 1'b0, 1'b0, 16'd0, 2, "chk0_after_rst", 1'b0, a0);
    send(CHK, 32'h1, 1'b0, 1'b0, 16'd0, 2, "chk1_after_rst2", 1'b0, a0);
    send(INS, 32'h0, 1'b0, 1'b0, 16'd1, 2, "ins0_post", 1'b0, a0);
    send(CHK, 32'h0, 1'b1, 1'b0, 16'd1, 2, "chk0_post", 1'b0, a0);
    drain();
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
